// File: rtl/rbe_store_serializer_pkg.sv
// Shared types and constants for the RBE store serializer.
// The optional 2-entry output skid stage is selected with the macro RBE_STORE_SER_SKID_EN.
package rbe_package;

    localparam int unsigned BINCONV_COLUMN_SIZE = 9;
    localparam int unsigned BINCONV_TP          = 32;
    localparam int unsigned STORE_SER_CNT_W     = 16;
    localparam int unsigned STORE_SER_COL_W     = $clog2(BINCONV_COLUMN_SIZE + 1);

    typedef struct packed {
        logic                       start;
        logic [STORE_SER_COL_W-1:0] nb_cols;
        logic [STORE_SER_CNT_W-1:0] nb_rows;
    } ctrl_store_ser_t;

    typedef struct packed {
        logic                       busy;
        logic                       done;
        logic [STORE_SER_COL_W-1:0] col_idx;
        logic [STORE_SER_CNT_W-1:0] row_cnt;
    } flags_store_ser_t;

    // Saturate a requested column count to the number of physical columns.
    function automatic logic [STORE_SER_COL_W-1:0] store_ser_clamp_cols(
        input logic [STORE_SER_COL_W-1:0] req,
        input int unsigned                max_cols
    );
        if (32'(req) > max_cols) begin
            return STORE_SER_COL_W'(max_cols);
        end
        return req;
    endfunction

endpackage

// File: rtl/rbe_store_serializer_skid.sv
// Two-entry skid FIFO used as the serializer output stage when
// RBE_STORE_SER_SKID_EN is defined. accept_o depends only on registered fill,
// so the sink ready never reaches the column readies combinationally.
module rbe_store_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [STRB_W-1:0] strb_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [STRB_W-1:0] strb_o,
    output logic              accept_o,
    output logic              drained_o
);

    logic [1:0]        fill_q, fill_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [STRB_W-1:0] strb0_q, strb0_d, strb1_q, strb1_d;
    logic              pop;

    assign pop       = enable_i & (fill_q != 2'd0) & ready_i;
    assign valid_o   = (fill_q != 2'd0);
    assign data_o    = data0_q;
    assign strb_o    = strb0_q;
    assign accept_o  = (fill_q != 2'd2);
    // Empty now, or the last entry leaves this cycle with nothing replacing it.
    assign drained_o = (fill_q == 2'd0) | ((fill_q == 2'd1) & pop & ~push_i);

    // Entry 0 is always the head; entry 1 only holds the second beat.
    always_comb begin
        fill_d  = fill_q;
        data0_d = data0_q;
        data1_d = data1_q;
        strb0_d = strb0_q;
        strb1_d = strb1_q;
        if (clear_i) begin
            fill_d = 2'd0;
        end else if (enable_i) begin
            case ({push_i, pop})
                2'b11: begin
                    if (fill_q == 2'd1) begin
                        data0_d = data_i;
                        strb0_d = strb_i;
                    end else begin
                        data0_d = data1_q;
                        strb0_d = strb1_q;
                        data1_d = data_i;
                        strb1_d = strb_i;
                    end
                end
                2'b01: begin
                    data0_d = data1_q;
                    strb0_d = strb1_q;
                    fill_d  = fill_q - 2'd1;
                end
                2'b10: begin
                    if (fill_q == 2'd0) begin
                        data0_d = data_i;
                        strb0_d = strb_i;
                    end else begin
                        data1_d = data_i;
                        strb1_d = strb_i;
                    end
                    fill_d = fill_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Storage and fill registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q  <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            strb0_q <= '0;
            strb1_q <= '0;
        end else begin
            fill_q  <= fill_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            strb0_q <= strb0_d;
            strb1_q <= strb1_d;
        end
    end

endmodule

// File: rtl/rbe_store_serializer.sv
// RBE store serializer: merges the per-column output streams into one stream,
// column 0..nb_cols-1 per row, for nb_rows rows.
// Define RBE_STORE_SER_SKID_EN to replace the single output register with a
// 2-entry skid FIFO (no combinational out_ready_i -> col_ready_o path).
module rbe_store_serializer
    import rbe_package::*;
#(
    parameter int unsigned BC_NR_COLUMN = rbe_package::BINCONV_COLUMN_SIZE,
    parameter int unsigned TP_IN        = rbe_package::BINCONV_TP,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  ctrl_store_ser_t                 ctrl_i,
    input  logic [BC_NR_COLUMN-1:0]         col_valid_i,
    input  logic [BC_NR_COLUMN*TP_IN-1:0]   col_data_i,
    input  logic [BC_NR_COLUMN*TP_IN/8-1:0] col_strb_i,
    output logic [BC_NR_COLUMN-1:0]         col_ready_o,
    output logic                            out_valid_o,
    output logic [TP_IN-1:0]                out_data_o,
    output logic [TP_IN/8-1:0]              out_strb_o,
    input  logic                            out_ready_i,
    output flags_store_ser_t                flags_o
);

    localparam int unsigned CW     = $clog2(BC_NR_COLUMN + 1);
    localparam int unsigned STRB_W = TP_IN / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_idx_q, col_idx_d;
    logic [CW-1:0]     nb_cols_q, nb_cols_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]  nb_rows_q, nb_rows_d;
    logic              done_q, done_d;

    logic              accept;
    logic              stage_drained;
    logic              run_ok;
    logic              col_hs;
    logic [TP_IN-1:0]  sel_data;
    logic [STRB_W-1:0] sel_strb;

    // Only the current column may be acknowledged, and only when the output stage has room.
    assign run_ok = (state_q == RUN) & enable_i & accept & ~clear_i;

    // Steer ready to col_idx and select its data/strb for the output stage.
    always_comb begin
        col_ready_o = '0;
        sel_data    = '0;
        sel_strb    = '0;
        for (int i = 0; i < BC_NR_COLUMN; i++) begin
            if (col_idx_q == CW'(i)) begin
                col_ready_o[i] = run_ok;
                sel_data       = col_data_i[i*TP_IN +: TP_IN];
                sel_strb       = col_strb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    assign col_hs = |(col_ready_o & col_valid_i);

    // Row/column counter FSM: next state, counters and done pulse.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_cnt_d = row_cnt_q;
        nb_cols_d = nb_cols_q;
        nb_rows_d = nb_rows_q;
        done_d    = 1'b0;
        if (clear_i) begin
            state_d   = IDLE;
            col_idx_d = '0;
            row_cnt_d = '0;
        end else if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (ctrl_i.start) begin
                        if ((ctrl_i.nb_rows == '0) || (ctrl_i.nb_cols == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d   = RUN;
                            col_idx_d = '0;
                            row_cnt_d = '0;
                            nb_cols_d = store_ser_clamp_cols(ctrl_i.nb_cols, BC_NR_COLUMN);
                            nb_rows_d = ctrl_i.nb_rows;
                        end
                    end
                end
                RUN: begin
                    if (col_hs) begin
                        if (col_idx_q == nb_cols_q - CW'(1)) begin
                            col_idx_d = '0;
                            row_cnt_d = row_cnt_q + CNT_W'(1);
                            if (row_cnt_q == nb_rows_q - CNT_W'(1)) begin
                                state_d = DRAIN;
                            end
                        end else begin
                            col_idx_d = col_idx_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (stage_drained) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            col_idx_q <= '0;
            row_cnt_q <= '0;
            nb_cols_q <= '0;
            nb_rows_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_cnt_q <= row_cnt_d;
            nb_cols_q <= nb_cols_d;
            nb_rows_q <= nb_rows_d;
            done_q    <= done_d;
        end
    end

`ifdef RBE_STORE_SER_SKID_EN
    rbe_store_skid #(
        .DATA_W (TP_IN),
        .STRB_W (STRB_W)
    ) i_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .clear_i   (clear_i),
        .push_i    (col_hs),
        .data_i    (sel_data),
        .strb_i    (sel_strb),
        .ready_i   (out_ready_i),
        .valid_o   (out_valid_o),
        .data_o    (out_data_o),
        .strb_o    (out_strb_o),
        .accept_o  (accept),
        .drained_o (stage_drained)
    );
`else
    logic              out_valid_q;
    logic [TP_IN-1:0]  out_data_q;
    logic [STRB_W-1:0] out_strb_q;

    // A pop and a push may coincide, which keeps throughput at one beat per cycle.
    assign accept        = ~out_valid_q | out_ready_i;
    assign stage_drained = ~out_valid_q | out_ready_i;

    // Single output register: load on column handshake, empty on sink handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
        end else if (clear_i) begin
            out_valid_q <= 1'b0;
        end else if (enable_i) begin
            if (col_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_strb_q  <= sel_strb;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
`endif

    // Status flags.
    always_comb begin
        flags_o         = '0;
        flags_o.busy    = (state_q != IDLE);
        flags_o.done    = done_q;
        flags_o.col_idx = col_idx_q;
        flags_o.row_cnt = row_cnt_q;
    end

endmodule

// File: tb/tb_rbe_store_serializer.sv
// Self-checking bench for rbe_store_serializer: randomized column sources and
// sink ready, checked against an in-order beat queue built from row/column order.
module tb_rbe_store_serializer;
    import rbe_package::*;

    localparam int NC = 9;
    localparam int TP = 32;
    localparam int SW = TP / 8;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 enable_i;
    logic                 clear_i;
    ctrl_store_ser_t      ctrl_i;
    logic [NC-1:0]        col_valid_i;
    logic [NC*TP-1:0]     col_data_i;
    logic [NC*SW-1:0]     col_strb_i;
    logic [NC-1:0]        col_ready_o;
    logic                 out_valid_o;
    logic [TP-1:0]        out_data_o;
    logic [SW-1:0]        out_strb_o;
    logic                 out_ready_i;
    flags_store_ser_t     flags_o;

    int n_vec = 0;
    int n_err = 0;

    logic [TP-1:0] src_d [NC][16];
    logic [SW-1:0] src_s [NC][16];
    int            ptr   [NC];
    logic [TP-1:0] exp_d [$];
    logic [SW-1:0] exp_s [$];

    rbe_store_serializer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .ctrl_i      (ctrl_i),
        .col_valid_i (col_valid_i),
        .col_data_i  (col_data_i),
        .col_strb_i  (col_strb_i),
        .col_ready_o (col_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_ready_i (out_ready_i),
        .flags_o     (flags_o)
    );

    always #5 clk = ~clk;

    task automatic check_idle_outputs(input string tag);
        n_vec++;
        if (col_ready_o !== '0 || out_valid_o !== 1'b0 || out_data_o !== '0 || out_strb_o !== '0 ||
            flags_o.busy !== 1'b0 || flags_o.done !== 1'b0 || flags_o.col_idx !== '0 || flags_o.row_cnt !== '0) begin
            n_err++;
            $display("FAIL %s: rdy=%h vld=%b data=%h strb=%h busy=%b done=%b col=%0d row=%0d, required all zero",
                     tag, col_ready_o, out_valid_o, out_data_o, out_strb_o, flags_o.busy, flags_o.done,
                     flags_o.col_idx, flags_o.row_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Full transfer against the reference queue. rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic run_xfer(input int nc_req, input int nr, input int rmode, input int vprob,
                            input bit pat, input bit start_mid, input string tag);
        int nc, total, pushes, pops, cyc, done_cnt, done_cyc, last_pop;
        bit stalled;
        logic [TP-1:0] held_d;
        logic [SW-1:0] held_s;
        logic [NC-1:0] exp_rdy;
        nc = (nc_req > NC) ? NC : nc_req;
        total = (nr == 0 || nc == 0) ? 0 : nc * nr;
        exp_d.delete();
        exp_s.delete();
        for (int c = 0; c < NC; c++) begin
            ptr[c] = 0;
            for (int r = 0; r < 16; r++) begin
                src_d[c][r] = pat ? TP'(16 * r + c) : TP'($urandom);
                src_s[c][r] = pat ? SW'(4'hF) : SW'($urandom);
            end
        end
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                exp_d.push_back(src_d[c][r]);
                exp_s.push_back(src_s[c][r]);
            end
        ctrl_i.start   = 1'b1;
        ctrl_i.nb_cols = STORE_SER_COL_W'(nc_req);
        ctrl_i.nb_rows = STORE_SER_CNT_W'(nr);
        @(posedge clk);
        #1;
        ctrl_i.start = 1'b0;
        pushes = 0; pops = 0; done_cnt = 0; done_cyc = -10; last_pop = -1; stalled = 0;
        held_d = '0; held_s = '0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (start_mid && cyc == 3) begin
                ctrl_i.start = 1'b1; ctrl_i.nb_cols = 4'd2; ctrl_i.nb_rows = 16'd1;
            end else begin
                ctrl_i.start = 1'b0;
            end
            for (int c = 0; c < NC; c++) begin
                col_valid_i[c] = (ptr[c] < nr) && ($urandom_range(0, 99) < vprob);
                col_data_i[c*TP +: TP] = (ptr[c] < 16) ? src_d[c][ptr[c]] : TP'($urandom);
                col_strb_i[c*SW +: SW] = (ptr[c] < 16) ? src_s[c][ptr[c]] : SW'($urandom);
            end
            case (rmode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready_i = ($urandom_range(0, 99) < 60);
            endcase
            @(negedge clk);
            exp_rdy = (pushes < total) ? NC'(1) << (pushes % nc) : '0;
            n_vec++;
            if ((col_ready_o & ~exp_rdy) !== '0) begin
                n_err++;
                $display("FAIL %s ready_steer: cyc %0d got %h allowed %h", tag, cyc, col_ready_o, exp_rdy);
            end
            if (stalled) begin
                n_vec++;
                if (out_valid_o !== 1'b1 || out_data_o !== held_d || out_strb_o !== held_s) begin
                    n_err++;
                    $display("FAIL %s stall_hold: cyc %0d got v=%b %h/%h required v=1 %h/%h",
                             tag, cyc, out_valid_o, out_data_o, out_strb_o, held_d, held_s);
                end
            end
            if (out_valid_o && out_ready_i) begin
                n_vec++;
                if (pops >= total) begin
                    n_err++;
                    $display("FAIL %s extra_beat: got %h beyond %0d beats", tag, out_data_o, total);
                end else if (out_data_o !== exp_d[pops] || out_strb_o !== exp_s[pops]) begin
                    n_err++;
                    $display("FAIL %s beat%0d: got %h/%h required %h/%h",
                             tag, pops, out_data_o, out_strb_o, exp_d[pops], exp_s[pops]);
                end
                pops++;
                last_pop = cyc;
            end
            stalled = out_valid_o && !out_ready_i;
            held_d = out_data_o;
            held_s = out_strb_o;
            for (int c = 0; c < NC; c++)
                if (col_ready_o[c] && col_valid_i[c]) begin
                    ptr[c]++;
                    pushes++;
                end
            if (flags_o.done) begin
                done_cnt++;
                done_cyc = cyc;
                n_vec++;
                if (flags_o.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_after_done: got %b required 0", tag, flags_o.busy);
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        col_valid_i = '0;
        out_ready_i = 1'b1;
        n_vec++;
        if (pops != total) begin
            n_err++;
            $display("FAIL %s beat_count: got %0d required %0d", tag, pops, total);
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d required 1", tag, done_cnt);
        end
        n_vec++;
        if (done_cyc != last_pop + 1) begin
            n_err++;
            $display("FAIL %s done_timing: got cycle %0d required %0d", tag, done_cyc, last_pop + 1);
        end
    endtask

    task automatic test_basic_order();
        run_xfer(9, 2, 0, 100, 1'b1, 1'b0, "basic_order");
    endtask

    task automatic test_backpressure();
        run_xfer(4, 3, 1, 100, 1'b0, 1'b0, "backpressure");
        run_xfer(4, 3, 1, 50, 1'b0, 1'b0, "backpressure_sparse");
    endtask

    task automatic test_boundary();
        run_xfer(9, 0, 0, 100, 1'b0, 1'b0, "rows_zero");
        run_xfer(0, 2, 0, 100, 1'b0, 1'b0, "cols_zero");
        run_xfer(12, 2, 2, 80, 1'b0, 1'b0, "cols_clamp");
        run_xfer(9, 3, 0, 100, 1'b0, 1'b1, "start_while_busy");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            run_xfer($urandom_range(1, 9), $urandom_range(1, 4), 2, 60, 1'b0, 1'b0, "random");
    endtask

    task automatic test_out_of_order();
        out_ready_i = 1'b1;
        col_valid_i = '0;
        ctrl_i.start = 1'b1; ctrl_i.nb_cols = 4'd9; ctrl_i.nb_rows = 16'd1;
        @(posedge clk);
        #1;
        ctrl_i.start = 1'b0;
        col_valid_i[3] = 1'b1;
        col_data_i[3*TP +: TP] = 32'h33;
        col_strb_i[3*SW +: SW] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (col_ready_o[3] !== 1'b0 || out_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL ooo_wait: rdy3=%b vld=%b required 0/0", col_ready_o[3], out_valid_o);
            end
            @(posedge clk);
            #1;
        end
        col_valid_i[0] = 1'b1;
        col_data_i[0 +: TP] = 32'hA0;
        col_strb_i[0 +: SW] = 4'h5;
        @(negedge clk);
        n_vec++;
        if (col_ready_o !== 9'h001) begin
            n_err++;
            $display("FAIL ooo_col0_ready: got %h required 001", col_ready_o);
        end
        @(posedge clk);
        #1;
        col_valid_i[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hA0 || out_strb_o !== 4'h5 || col_ready_o[3] !== 1'b0) begin
            n_err++;
            $display("FAIL ooo_col0_first: got v=%b %h/%h rdy3=%b required v=1 a0/5 rdy3=0",
                     out_valid_o, out_data_o, out_strb_o, col_ready_o[3]);
        end
        @(posedge clk);
        #1;
        clear_i = 1'b1;
        col_valid_i = '0;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        int beats;
        out_ready_i = 1'b1;
        for (int c = 0; c < NC; c++) begin
            col_data_i[c*TP +: TP] = TP'(c);
            col_strb_i[c*SW +: SW] = 4'hF;
        end
        col_valid_i = '1;
        ctrl_i.start = 1'b1; ctrl_i.nb_cols = 4'd9; ctrl_i.nb_rows = 16'd2;
        @(posedge clk);
        #1;
        ctrl_i.start = 1'b0;
        beats = 0;
        for (int i = 0; i < 100 && beats < 5; i++) begin
            @(negedge clk);
            if (out_valid_o && out_ready_i) beats++;
            @(posedge clk);
            #1;
        end
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid_o !== 1'b0 || flags_o.busy !== 1'b0 || flags_o.done !== 1'b0) begin
            n_err++;
            $display("FAIL clear_effect: v=%b busy=%b done=%b required 0/0/0", out_valid_o, flags_o.busy, flags_o.done);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (flags_o.done !== 1'b0 || out_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL clear_no_done: done=%b v=%b required 0/0", flags_o.done, out_valid_o);
            end
        end
        @(posedge clk);
        #1;
        col_valid_i = '0;
        run_xfer(9, 2, 2, 80, 1'b0, 1'b0, "after_clear");
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b1;
        col_valid_i = '1;
        ctrl_i.start = 1'b1; ctrl_i.nb_cols = 4'd9; ctrl_i.nb_rows = 16'd2;
        @(posedge clk);
        #1;
        ctrl_i.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (flags_o.done !== 1'b0 || out_valid_o !== 1'b0 || flags_o.busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset: done=%b v=%b busy=%b required 0/0/0",
                         flags_o.done, out_valid_o, flags_o.busy);
            end
        end
        @(posedge clk);
        #1;
        col_valid_i = '0;
        run_xfer(9, 2, 0, 100, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        rst_ni      = 1'b0;
        enable_i    = 1'b1;
        clear_i     = 1'b0;
        ctrl_i      = '0;
        col_valid_i = '0;
        col_data_i  = '0;
        col_strb_i  = '0;
        out_ready_i = 1'b0;
        test_reset();
        test_basic_order();
        test_out_of_order();
        test_backpressure();
        test_boundary();
        test_clear();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
